dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the MIPS pipeline's memory stage. It accepts one load or store request at a time from the core: a word address, 4-bit big-endian byte enables and write data. It then answers after a programmable number of wait states with read data or an error flag, and drives a stall to the hazard unit while the request is outstanding. It is the memory-side end of the core's M-stage load/store interface.

## Interface
- `DEPTH_LOG2`, default 10: log2 of the number of 32-bit words stored.
- `WAIT`, default 1, legal range 0..7: wait cycles inserted between accept and response.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_en`  in  1  request present this cycle.
- `req_addr`  in  32  byte address.
- `req_be`  in  4  byte enables; `4'b0000` means read, nonzero means write. `be[3]` maps to byte offset 0 = `wdata[31:24]`, and `be[0]` maps to offset 3 = `wdata[7:0]`.
- `req_wdata`  in  32  store data, already lane-replicated by the core.
- `req_ready`  out  1  request accepted this cycle when `req_en & req_ready`.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  full word read; the core extracts the lane. Held between responses.
- `rsp_err`  out  1  request rejected; valid with `rsp_valid`.
- `stall`  out  1  freeze request to the hazard unit.

## Operation
- FSM states:
  - IDLE: `req_ready=1`. On accept, latch addr/be/wdata; go to WAIT if `WAIT>0` (counter loaded with `WAIT-1`), else to RESP.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP: `rsp_valid=1` for exactly one cycle, then return to IDLE.
- `req_ready=0` in WAIT and RESP. Requests presented there are ignored, not queued.
- Word index is `addr[DEPTH_LOG2+1:2]`. Address out of range (any of `addr[31:DEPTH_LOG2+2]` nonzero) → error.
- Legal byte-enable/offset pairs; anything else → error:
  - `be=0000`: any offset.
  - `be=1111`: `addr[1:0]=00`.
  - `be=1100`: `addr[1]=0`.
  - `be=0011`: `addr[1]=1`.
  - `be=1000` / `0100` / `0010` / `0001`: `addr[1:0]` = 00 / 01 / 10 / 11 respectively.
- Stores: enabled bytes are written on the edge entering RESP; disabled bytes are unchanged.
- Loads: `rsp_rdata` captures the addressed word on the edge entering RESP.
- Any error: no write; `rsp_err=1`; `rsp_rdata=0`.
- `stall = (state==WAIT) | (state==IDLE & req_en)`. `stall` is low in RESP so the core advances on the response cycle.

## Timing
- Latency: `rsp_valid` rises exactly `WAIT+1` cycles after the accept edge. Throughput is one request per `WAIT+2` cycles.
- Reset (rst=0) values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, counter 0.
- Storage array contents are not reset.
- Reset asserted in WAIT, or before the edge entering RESP, aborts the request: no write, no response.
- `req_en` asserted in the RESP cycle is not accepted. It is accepted the following IDLE cycle if still held.
- Inputs are sampled only at accept; changes on inputs during WAIT have no effect.
- `WAIT=0`: state goes IDLE→RESP→IDLE, and `stall` is high for the accept cycle only.

## Structure
- Package `dmem_pkg`: state enum (IDLE, WAIT, RESP), `BE_*` legal-pattern constants, and function `be_legal(be, off)`.
- Sub-module `dmem_bram_be`: synchronous single-port word RAM with 4 per-byte write enables (big-endian lane order) and a registered read. It is instantiated once; the FSM, legality check and stall logic stay at the top level.

## Test plan
- **Word store/load, WAIT=1:** write `addr=0x10, be=1111, wdata=0xDEADBEEF`, then read `0x10`. Expect `rsp_valid` 2 cycles after each accept, `rsp_rdata=0xDEADBEEF`, `rsp_err=0`.
- **Byte and half stores:**
  - `sb` `addr=0x11, be=0100, wdata=0x55555555` onto word `0xDEADBEEF` → read gives `0xDE55BEEF`.
  - `sh` `addr=0x12, be=0011, wdata=0x12341234` → read gives `0xDE551234`.
- **Illegal requests:**
  - `be=1111` at `addr=0x13` → `rsp_err=1`, `rsp_rdata=0`, and the word is unchanged.
  - Address `0x0010_0000` with `DEPTH_LOG2=10` → `rsp_err=1`.
- **Stall and back-to-back, WAIT=3:**
  - `stall` is high for 4 cycles (accept plus 3 WAIT) and low in RESP.
  - A second `req_en` held through the response is accepted on the first cycle after RESP.
- **Reset mid-operation:** store `0xAAAAAAAA` to `0x20`, assert `rst=0` in WAIT → no `rsp_valid`. After release, read `0x20` → old contents.
- **WAIT=0:** a load returns `rsp_valid` on the cycle after accept, with no idle bubble other than the RESP cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and byte-enable legality rules for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_B0   = 4'b1000;
    localparam logic [3:0] BE_B1   = 4'b0100;
    localparam logic [3:0] BE_B2   = 4'b0010;
    localparam logic [3:0] BE_B3   = 4'b0001;

    function automatic logic be_legal(input logic [3:0] be,
                                      input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (be)
            BE_NONE: ok = 1'b1;
            BE_WORD: ok = (off == 2'b00);
            BE_HI:   ok = ~off[1];
            BE_LO:   ok = off[1];
            BE_B0:   ok = (off == 2'b00);
            BE_B1:   ok = (off == 2'b01);
            BE_B2:   ok = (off == 2'b10);
            BE_B3:   ok = (off == 2'b11);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_bram_be.sv
// Single-port word RAM with big-endian byte write enables and a registered read.
module dmem_bram_be #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [1<<AW];
    logic [31:0] rdata_q;

    // we_i[3] is byte offset 0, which sits in wdata[31:24]
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (en_i && we_i == 4'b0000) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: one request at a time, fixed wait states,
// byte-enable legality and range checking, stall to the hazard unit.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam logic [2:0] WAIT_LD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        ready_q;
    logic        valid_q;
    logic        err_q;

    logic        idle;
    logic        go_resp;
    logic        bad;
    logic        ram_en;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic [31:0] ram_rdata;

    assign idle = (state_q == ST_IDLE);

    // With no wait states the RAM is accessed on the accept edge itself,
    // so the live inputs are used instead of the latched copy.
    assign cur_addr  = idle ? req_addr  : addr_q;
    assign cur_be    = idle ? req_be    : be_q;
    assign cur_wdata = idle ? req_wdata : wdata_q;

    assign bad = (|cur_addr[31:DEPTH_LOG2+2])
               | ~be_legal(cur_be, cur_addr[1:0]);

    assign go_resp = idle ? (req_en && WAIT == 0)
                          : (state_q == ST_WAIT && cnt_q == 3'd0);

    assign ram_en = go_resp & ~bad & rst;

    dmem_bram_be #(
        .AW(DEPTH_LOG2)
    ) u_ram (
        .clk    (clk),
        .rst_ni (rst),
        .en_i   (ram_en),
        .we_i   (cur_be),
        .addr_i (cur_addr[DEPTH_LOG2+1:2]),
        .wdata_i(cur_wdata),
        .rdata_o(ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= go_resp;
            if (go_resp) err_q <= bad;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_en) begin
                        addr_q  <= req_addr;
                        be_q    <= req_be;
                        wdata_q <= req_wdata;
                        ready_q <= 1'b0;
                        if (WAIT == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_LD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) state_q <= ST_RESP;
                    else cnt_q <= cnt_q - 3'd1;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_err   = valid_q & err_q;
    assign rsp_rdata = err_q ? 32'd0 : ram_rdata;
    assign stall     = (state_q == ST_WAIT) | (idle & req_en);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at WAIT=1, WAIT=3 and WAIT=0.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_en    [3];
    logic [31:0] req_addr  [3];
    logic [3:0]  req_be    [3];
    logic [31:0] req_wdata [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        stall     [3];

    int n_chk;
    int n_fail;

    dmem_responder #(.DEPTH_LOG2(10), .WAIT(1)) u_w1 (
        .clk(clk), .rst(rst),
        .req_en(req_en[0]), .req_addr(req_addr[0]),
        .req_be(req_be[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .stall(stall[0])
    );

    dmem_responder #(.DEPTH_LOG2(10), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst),
        .req_en(req_en[1]), .req_addr(req_addr[1]),
        .req_be(req_be[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .stall(stall[1])
    );

    dmem_responder #(.DEPTH_LOG2(10), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst),
        .req_en(req_en[2]), .req_addr(req_addr[2]),
        .req_be(req_be[2]), .req_wdata(req_wdata[2]),
        .req_ready(req_ready[2]), .rsp_valid(rsp_valid[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
        .stall(stall[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; returns the cycle index of rsp_valid (accept cycle = 0).
    task automatic do_req(input int d, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          output logic err, output logic [31:0] rd,
                          output int lat);
        lat = -1;
        err = 1'bx;
        rd  = 'x;
        @(negedge clk);
        req_en[d]    = 1'b1;
        req_addr[d]  = a;
        req_be[d]    = be;
        req_wdata[d] = wd;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req_en[d] = 1'b0;
            if (rsp_valid[d]) begin
                lat = k;
                err = rsp_err[d];
                rd  = rsp_rdata[d];
                break;
            end
        end
    endtask

    // Hold req_en for n cycles and compare per-cycle stall/valid/ready bits.
    task automatic hold_seq(input int d, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd,
                            input int n, input logic [15:0] st,
                            input logic [15:0] vl, input logic [15:0] rd);
        @(negedge clk);
        req_en[d]    = 1'b1;
        req_addr[d]  = a;
        req_be[d]    = be;
        req_wdata[d] = wd;
        #1;
        for (int k = 0; k < n; k++) begin
            check($sformatf("d%0d stall c%0d", d, k), 32'(stall[d]), 32'(st[k]));
            check($sformatf("d%0d valid c%0d", d, k), 32'(rsp_valid[d]), 32'(vl[k]));
            check($sformatf("d%0d ready c%0d", d, k), 32'(req_ready[d]), 32'(rd[k]));
            @(negedge clk);
            #1;
        end
        req_en[d] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] r;
        int          l;

        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req_en[d]    = 1'b0;
            req_addr[d]  = '0;
            req_be[d]    = '0;
            req_wdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d rst ready", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("d%0d rst valid", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("d%0d rst err", d), 32'(rsp_err[d]), 32'd0);
            check($sformatf("d%0d rst rdata", d), rsp_rdata[d], 32'd0);
            check($sformatf("d%0d rst stall", d), 32'(stall[d]), 32'd0);
        end

        // WAIT=1 word store then load
        do_req(0, 32'h10, 4'b1111, 32'hDEADBEEF, e, r, l);
        check("sw lat", 32'(l), 32'd2);
        check("sw err", 32'(e), 32'd0);
        do_req(0, 32'h10, 4'b0000, 32'h0, e, r, l);
        check("lw lat", 32'(l), 32'd2);
        check("lw err", 32'(e), 32'd0);
        check("lw data", r, 32'hDEADBEEF);

        do_req(0, 32'h11, 4'b0100, 32'h55555555, e, r, l);
        check("sb err", 32'(e), 32'd0);
        do_req(0, 32'h10, 4'b0000, 32'h0, e, r, l);
        check("sb data", r, 32'hDE55BEEF);

        do_req(0, 32'h12, 4'b0011, 32'h12341234, e, r, l);
        check("sh err", 32'(e), 32'd0);
        do_req(0, 32'h10, 4'b0000, 32'h0, e, r, l);
        check("sh data", r, 32'hDE551234);

        // illegal requests
        do_req(0, 32'h13, 4'b1111, 32'hFFFFFFFF, e, r, l);
        check("mis lat", 32'(l), 32'd2);
        check("mis err", 32'(e), 32'd1);
        check("mis rdata", r, 32'd0);
        do_req(0, 32'h10, 4'b0011, 32'h0000ABCD, e, r, l);
        check("sh off0 err", 32'(e), 32'd1);
        do_req(0, 32'h10, 4'b0000, 32'h0, e, r, l);
        check("mis keep err", 32'(e), 32'd0);
        check("mis keep data", r, 32'hDE551234);
        do_req(0, 32'h0010_0000, 4'b0000, 32'h0, e, r, l);
        check("oor ld err", 32'(e), 32'd1);
        check("oor ld rdata", r, 32'd0);
        do_req(0, 32'h0010_0010, 4'b1111, 32'h0BADF00D, e, r, l);
        check("oor st err", 32'(e), 32'd1);
        do_req(0, 32'h10, 4'b0000, 32'h0, e, r, l);
        check("oor keep data", r, 32'hDE551234);

        // WAIT=3: two back-to-back stores with req_en held throughout
        hold_seq(1, 32'h40, 4'b1111, 32'h11223344, 10,
                 16'b0000_0001_1110_1111,
                 16'b0000_0010_0001_0000,
                 16'b0000_0000_0010_0001);
        do_req(1, 32'h40, 4'b0000, 32'h0, e, r, l);
        check("w3 lat", 32'(l), 32'd4);
        check("w3 data", r, 32'h11223344);

        // reset during WAIT aborts the store
        do_req(0, 32'h20, 4'b1111, 32'h01020304, e, r, l);
        check("pre sw err", 32'(e), 32'd0);
        @(negedge clk);
        req_en[0]    = 1'b1;
        req_addr[0]  = 32'h20;
        req_be[0]    = 4'b1111;
        req_wdata[0] = 32'hAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        req_en[0] = 1'b0;
        #1;
        check("rst mid valid", 32'(rsp_valid[0]), 32'd0);
        check("rst mid ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst post valid %0d", k), 32'(rsp_valid[0]), 32'd0);
        end
        do_req(0, 32'h20, 4'b0000, 32'h0, e, r, l);
        check("rst keep data", r, 32'h01020304);

        // WAIT=0
        do_req(2, 32'h8, 4'b1111, 32'hCAFEF00D, e, r, l);
        check("w0 sw lat", 32'(l), 32'd1);
        do_req(2, 32'h8, 4'b0000, 32'h0, e, r, l);
        check("w0 lw lat", 32'(l), 32'd1);
        check("w0 lw data", r, 32'hCAFEF00D);
        hold_seq(2, 32'h8, 4'b0000, 32'h0, 4,
                 16'b0000_0000_0000_0101,
                 16'b0000_0000_0000_1010,
                 16'b0000_0000_0000_0101);
        check("w0 b2b data", rsp_rdata[2], 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
